regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised register file with a per-register busy scoreboard, for the single-cycle and upcoming multi-cycle datapaths. It provides two combinational read ports and one write port, an optional write-to-read bypass, and an optional hardwired zero register. A reservation port marks a destination register busy when a multi-cycle producer issues; the matching write-back clears it. The per-port busy flags let the control unit stall on read-after-write hazards.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W registers; legal range 2..6
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and ignores reservations
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs  input  ADDR_W  read port 1 address
- rt  input  ADDR_W  read port 2 address
- read1  output  DATA_W  read port 1 data (combinational)
- read2  output  DATA_W  read port 2 data (combinational)
- busy1  output  1  register at rs has an outstanding reservation
- busy2  output  1  register at rt has an outstanding reservation
- wen  input  1  write enable
- rd  input  ADDR_W  write address
- wdat  input  DATA_W  write data
- resv_en  input  1  reserve request
- resv_rd  input  ADDR_W  register to mark busy

## Operation
- State:
  - data array of 2^ADDR_W × DATA_W
  - busy vector of 2^ADDR_W bits
- Reset: a rising edge with rst=1 clears every data entry and every busy bit to 0. Writes and reservations in that cycle are discarded.
- While rst=1, read1, read2, busy1 and busy2 are forced to 0.
- Write: a rising edge with wen=1 stores wdat to data[rd] and clears busy[rd]. This is suppressed when ZERO_REG=1 and rd=0.
- Reserve: a rising edge with resv_en=1 sets busy[resv_rd]. This is suppressed when ZERO_REG=1 and resv_rd=0.
- Write and reserve to the same register in the same cycle: data is updated and busy ends at 1 (reserve wins). This is the case of a new producer issuing as the old one retires.
- Write and reserve to different registers in the same cycle: both take effect.
- Reserve to a register that is already busy: busy stays 1. There is no counting; one write-back clears it.
- Write to a non-busy register: allowed, and busy stays 0.
- Read port 1 (port 2 is identical with rt, read2, busy2):
  - If ZERO_REG=1 and rs=0: read1=0, busy1=0.
  - Else if BYPASS=1, wen=1 and rd=rs (rd not a suppressed zero write): read1=wdat, busy1=0.
  - Else: read1=data[rs], busy1=busy[rs].
- Both ports may address the same register, and both then return identical values.
- Width rules:
  - Addresses are unsigned and every value indexes a real entry; there is no out-of-range case.
  - Data is stored verbatim, with no extension or masking.

## Timing
- Read latency is 0 cycles (purely combinational from rs/rt, the array and the write port).
- Write-to-read latency:
  - BYPASS=1: the written value is visible in the same cycle via forwarding, and in the array from the next cycle.
  - BYPASS=0: the written value is visible one cycle after the write edge.
- Reserve-to-busy latency: busy is visible one cycle after the reserve edge. A reserve never bypasses to the same-cycle busy outputs.
- Write-back-to-not-busy latency:
  - BYPASS=1: 0 cycles (same cycle).
  - BYPASS=0: 1 cycle.
- Reset mid-operation: all reservations are lost and all data reads 0 from the first cycle after rst deasserts. In-flight producers must be flushed by the control unit.
- No output is registered; the read path is a combinational path that downstream logic must time.

## Test plan
- Reset then read all 32 addresses on both ports -> read1=read2=0, busy1=busy2=0. Also check that wen=1, rd=3, wdat=0xDEAD during rst=1 leaves data[3]=0.
- Write 0x12345678 to r5, then the next cycle rs=rt=5 -> both ports read 0x12345678. With BYPASS=1, rs=5 in the write cycle also shows 0x12345678. With BYPASS=0, the same-cycle read shows the old value 0.
- Write 0xFFFFFFFF to r0 and reserve r0 (ZERO_REG=1) -> read1=0 and busy1=0 on every later cycle. With ZERO_REG=0, the next cycle reads 0xFFFFFFFF.
- Reserve r8, then rs=8 for 3 idle cycles -> busy1=1 throughout. Write 0xA5A5A5A5 to r8 -> busy1=0 and read1=0xA5A5A5A5 in that cycle (BYPASS=1), and these values hold afterwards.
- Write r9=0x11 and reserve r9 in the same cycle -> next cycle read1=0x11, busy1=1. Reserve r10 and write r11=0x22 in the same cycle -> busy[10]=1, data[11]=0x22, busy[11]=0.
- Reserve r4, then assert rst for 1 cycle -> busy2 for rt=4 reads 0 after reset. Repeat with ADDR_W=6, DATA_W=64: write r63=0x0123456789ABCDEF and read it back intact.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a
// per-register busy scoreboard used by the control unit to stall on RAW hazards.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wdat,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_rd
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ok;
  logic              resv_ok;

  // Register 0 swallows writes and reservations when it is hardwired to zero.
  always_comb begin
    wr_ok   = wen && !(ZERO_REG && (rd == '0));
    resv_ok = resv_en && !(ZERO_REG && (resv_rd == '0));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      busy_d[i] = busy_q[i];
      if (rst) begin
        data_d[i] = '0;
        busy_d[i] = 1'b0;
      end else begin
        if (wr_ok && (rd == ADDR_W'(i))) begin
          data_d[i] = wdat;
          busy_d[i] = 1'b0;
        end
        // A new producer issuing as the old one retires leaves the entry busy.
        if (resv_ok && (resv_rd == ADDR_W'(i))) begin
          busy_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      data_q[i] <= data_d[i];
    end
    busy_q <= busy_d;
  end

  // Returns {busy, data} for one read address.
  function automatic logic [DATA_W:0] port_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] res;
    res = '0;
    if (rst || (ZERO_REG && (addr == '0))) begin
      res = '0;
    end else if (BYPASS && wr_ok && (rd == addr)) begin
      res = {1'b0, wdat};
    end else begin
      res = {busy_q[addr], data_q[addr]};
    end
    return res;
  endfunction

  always_comb begin
    {busy1, read1} = port_read(rs);
    {busy2, read2} = port_read(rt);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations are queued as stimulus
// is driven and popped against three differently parameterised instances.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs, rt, rd, resv_rd;
  logic        wen, resv_en;
  logic [31:0] wdat;

  logic [31:0] read1_m, read2_m, read1_n, read2_n;
  logic        busy1_m, busy2_m, busy1_n, busy2_n;

  logic [5:0]  w_rs, w_rt, w_rd, w_resv_rd;
  logic        w_wen, w_resv_en;
  logic [63:0] w_wdat, read1_w, read2_w;
  logic        busy1_w, busy2_w;

  // Main instance: ZERO_REG=1, BYPASS=1
  regfile_scoreboard u_main (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt),
    .read1(read1_m), .read2(read2_m), .busy1(busy1_m), .busy2(busy2_m),
    .wen(wen), .rd(rd), .wdat(wdat), .resv_en(resv_en), .resv_rd(resv_rd)
  );

  // Same stimulus, ZERO_REG=0, BYPASS=0
  regfile_scoreboard #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt),
    .read1(read1_n), .read2(read2_n), .busy1(busy1_n), .busy2(busy2_n),
    .wen(wen), .rd(rd), .wdat(wdat), .resv_en(resv_en), .resv_rd(resv_rd)
  );

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(6)) u_wide (
    .clk(clk), .rst(rst), .rs(w_rs), .rt(w_rt),
    .read1(read1_w), .read2(read2_w), .busy1(busy1_w), .busy2(busy2_w),
    .wen(w_wen), .rd(w_rd), .wdat(w_wdat), .resv_en(w_resv_en), .resv_rd(w_resv_rd)
  );

  typedef struct {
    string       tag;
    int          sel;   // 0/1 main p1/p2, 2/3 nb p1/p2, 4/5 wide p1/p2
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input int sel, input logic [63:0] data, input logic busy);
    exp_t e;
    e.tag = tag; e.sel = sel; e.data = data; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [63:0] od;
    logic        ob;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin od = {32'h0, read1_m}; ob = busy1_m; end
        1:       begin od = {32'h0, read2_m}; ob = busy2_m; end
        2:       begin od = {32'h0, read1_n}; ob = busy1_n; end
        3:       begin od = {32'h0, read2_n}; ob = busy2_n; end
        4:       begin od = read1_w; ob = busy1_w; end
        default: begin od = read2_w; ob = busy2_w; end
      endcase
      n_assert++;
      assert (od === e.data) else begin
        n_fail++;
        $error("FAIL %s data: observed %h expected %h", e.tag, od, e.data);
      end
      n_assert++;
      assert (ob === e.busy) else begin
        n_fail++;
        $error("FAIL %s busy: observed %b expected %b", e.tag, ob, e.busy);
      end
      $display("check %s sel=%0d data=%h busy=%b", e.tag, e.sel, od, ob);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; resv_en = 1'b0; w_wen = 1'b0; w_resv_en = 1'b0;
  endtask

  initial begin
    // Reset with a write and reserve that must be discarded.
    rst = 1'b1; wen = 1'b1; rd = 5'd3; wdat = 32'hDEAD;
    resv_en = 1'b1; resv_rd = 5'd3; rs = 5'd3; rt = 5'd3;
    w_wen = 1'b0; w_resv_en = 1'b0; w_rd = '0; w_resv_rd = '0; w_wdat = '0;
    w_rs = '0; w_rt = '0;
    push("rst_force_p1", 0, 64'h0, 1'b0);
    push("rst_force_p2", 1, 64'h0, 1'b0);
    check_all();
    tick();
    rst = 1'b0; idle();

    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(31 - i);
      push("post_rst_p1", 0, 64'h0, 1'b0);
      push("post_rst_p2", 1, 64'h0, 1'b0);
      check_all();
      tick();
    end

    // Write r5: bypass on main, old value on the non-bypass instance.
    wen = 1'b1; rd = 5'd5; wdat = 32'h12345678; rs = 5'd5; rt = 5'd5;
    push("wr5_bypass", 0, 64'h12345678, 1'b0);
    push("wr5_nobyp", 2, 64'h0, 1'b0);
    check_all();
    tick(); idle();
    push("rd5_p1", 0, 64'h12345678, 1'b0);
    push("rd5_p2", 1, 64'h12345678, 1'b0);
    push("rd5_nb_p1", 2, 64'h12345678, 1'b0);
    push("rd5_nb_p2", 3, 64'h12345678, 1'b0);
    check_all();
    tick();

    // Write and reserve r0.
    wen = 1'b1; rd = 5'd0; wdat = 32'hFFFFFFFF; resv_en = 1'b1; resv_rd = 5'd0;
    rs = 5'd0; rt = 5'd0;
    push("r0_same", 0, 64'h0, 1'b0);
    check_all();
    tick(); idle();
    push("r0_zero", 0, 64'h0, 1'b0);
    push("r0_nz", 2, 64'hFFFFFFFF, 1'b1);
    check_all();
    tick();
    push("r0_zero_later", 0, 64'h0, 1'b0);
    check_all();
    tick();

    // Reserve r8, hold, then write back.
    resv_en = 1'b1; resv_rd = 5'd8; rs = 5'd8;
    push("r8_resv_cycle", 0, 64'h0, 1'b0);
    check_all();
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      push("r8_busy", 0, 64'h0, 1'b1);
      check_all();
      tick();
    end
    wen = 1'b1; rd = 5'd8; wdat = 32'hA5A5A5A5;
    push("r8_wb_bypass", 0, 64'hA5A5A5A5, 1'b0);
    push("r8_wb_nobyp", 2, 64'h0, 1'b1);
    check_all();
    tick(); idle();
    push("r8_after", 0, 64'hA5A5A5A5, 1'b0);
    push("r8_after_nb", 2, 64'hA5A5A5A5, 1'b0);
    check_all();
    tick();

    // Write and reserve r9 together: reserve wins.
    wen = 1'b1; rd = 5'd9; wdat = 32'h11; resv_en = 1'b1; resv_rd = 5'd9;
    tick(); idle();
    rs = 5'd9;
    push("r9_wr_resv", 0, 64'h11, 1'b1);
    check_all();
    tick();

    // Reserve r10 while writing r11.
    resv_en = 1'b1; resv_rd = 5'd10; wen = 1'b1; rd = 5'd11; wdat = 32'h22;
    rs = 5'd10; rt = 5'd11;
    push("r10_same", 0, 64'h0, 1'b0);
    push("r11_same", 1, 64'h22, 1'b0);
    check_all();
    tick(); idle();
    push("r10_busy", 0, 64'h0, 1'b1);
    push("r11_data", 1, 64'h22, 1'b0);
    check_all();
    tick();

    // Reserve r4, then reset mid-operation.
    resv_en = 1'b1; resv_rd = 5'd4; rt = 5'd4; rs = 5'd11;
    tick(); idle();
    push("r4_busy", 1, 64'h0, 1'b1);
    check_all();
    rst = 1'b1;
    push("r4_rst_force", 1, 64'h0, 1'b0);
    push("r11_rst_force", 0, 64'h0, 1'b0);
    check_all();
    tick();
    rst = 1'b0;
    push("r4_after_rst", 1, 64'h0, 1'b0);
    push("r11_after_rst", 0, 64'h0, 1'b0);
    check_all();
    tick();

    // Wide instance: 64-bit data through r63.
    w_wen = 1'b1; w_rd = 6'd63; w_wdat = 64'h0123456789ABCDEF; w_rs = 6'd63; w_rt = 6'd62;
    push("w63_bypass", 4, 64'h0123456789ABCDEF, 1'b0);
    push("w62_zero", 5, 64'h0, 1'b0);
    check_all();
    tick(); idle();
    w_rt = 6'd63;
    push("w63_p1", 4, 64'h0123456789ABCDEF, 1'b0);
    push("w63_p2", 5, 64'h0123456789ABCDEF, 1'b0);
    check_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
